// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle between IF/ID, WB, EX and the decode stage.
// The decode stage connects through the slave modport; the driver of its inputs uses master.
interface id_stage_pipe_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic              i_valid;
   logic [31:0]       i_inst;
   logic [XLEN-1:0]   i_pc;
   logic              o_ready;
   logic              i_flush;
   logic              i_ex_ready;
   logic              i_wb_wren;
   logic [4:0]        i_wb_rd;
   logic [XLEN-1:0]   i_wb_data;
   logic              o_valid;
   logic [XLEN-1:0]   o_pc;
   logic [XLEN-1:0]   o_rs1_data;
   logic [XLEN-1:0]   o_rs2_data;
   logic [XLEN-1:0]   o_imm;
   logic [4:0]        o_rs1;
   logic [4:0]        o_rs2;
   logic [4:0]        o_rd;
   logic [6:0]        o_opcode;
   logic [2:0]        o_funct3;
   logic              o_funct7b5;
   logic              o_reg_wren;
   logic              o_mem_rd;
   logic              o_mem_wren;
   logic              o_illegal;
   logic [CNT_W-1:0]  o_stall_cnt;

   modport master (
      output i_valid, i_inst, i_pc, i_flush, i_ex_ready, i_wb_wren, i_wb_rd, i_wb_data,
      input  o_ready, o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd,
             o_opcode, o_funct3, o_funct7b5, o_reg_wren, o_mem_rd, o_mem_wren, o_illegal,
             o_stall_cnt
   );

   modport slave (
      input  i_valid, i_inst, i_pc, i_flush, i_ex_ready, i_wb_wren, i_wb_rd, i_wb_data,
      output o_ready, o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd,
             o_opcode, o_funct3, o_funct7b5, o_reg_wren, o_mem_rd, o_mem_wren, o_illegal,
             o_stall_cnt
   );
endinterface

// File: rtl/id_stage_pipe.sv
// RV decode stage with register file, immediate generation, load-use hazard detection
// and a registered ID/EX pipeline stage with valid/ready back-pressure and flush.
module id_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1,
   parameter int CNT_W  = 16
) (
   input logic             i_clk,
   input logic             i_reset_n,
   id_stage_pipe_if.slave  bus
);
   localparam int         AW     = $clog2(NREG);
   localparam logic [5:0] NREG_L = 6'(NREG);

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_e;

   logic [XLEN-1:0] rf [NREG];
   logic [31:0]     inst;
   logic [6:0]      opc;
   logic [4:0]      rs1, rs2, rd;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm, rs1_val, rs2_val;
   logic            legal, use_rs1, use_rs2, writes_rd, illegal;
   logic            advance, hazard, wb_we;

   function automatic logic in_range(input logic [4:0] idx);
      return {1'b0, idx} < NREG_L;
   endfunction

   assign inst = bus.i_inst;
   assign opc  = inst[6:0];
   assign rs1  = inst[19:15];
   assign rs2  = inst[24:20];
   assign rd   = inst[11:7];
   assign wb_we = bus.i_wb_wren && (bus.i_wb_rd != 5'd0) && in_range(bus.i_wb_rd);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned k = 0; k < NREG; k++) rf[k] <= '0;
      end else if (wb_we) begin
         rf[bus.i_wb_rd[AW-1:0]] <= bus.i_wb_data;
      end
   end

   // Write-first bypass only when BYPASS is set; x0 and out-of-range indices read zero.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0 && in_range(rs1)) begin
         if (BYPASS != 0 && bus.i_wb_wren && bus.i_wb_rd == rs1) rs1_val = bus.i_wb_data;
         else                                                    rs1_val = rf[rs1[AW-1:0]];
      end
      if (rs2 != 5'd0 && in_range(rs2)) begin
         if (BYPASS != 0 && bus.i_wb_wren && bus.i_wb_rd == rs2) rs2_val = bus.i_wb_data;
         else                                                    rs2_val = rf[rs2[AW-1:0]];
      end
   end

   always_comb begin
      imm32     = '0;
      legal     = 1'b1;
      use_rs1   = 1'b1;
      use_rs2   = 1'b0;
      writes_rd = 1'b1;
      case (opc)
         OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
         OP_STORE: begin
            imm32     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
         end
         OP_BRANCH: begin
            imm32     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            use_rs2   = 1'b1;
            writes_rd = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {inst[31:12], 12'b0};
            use_rs1 = 1'b0;
         end
         OP_JAL: begin
            imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            use_rs1 = 1'b0;
         end
         OP_REG: use_rs2 = 1'b1;
         default: begin
            legal     = 1'b0;
            use_rs1   = 1'b0;
            writes_rd = 1'b0;
         end
      endcase
      illegal = !legal || (writes_rd && !in_range(rd)) ||
                (use_rs1 && !in_range(rs1)) || (use_rs2 && !in_range(rs2));
   end

   assign imm     = XLEN'($signed(imm32));
   assign advance = !bus.o_valid || bus.i_ex_ready;
   assign hazard  = bus.i_valid && bus.o_valid && bus.o_mem_rd && (bus.o_rd != 5'd0) &&
                    ((use_rs1 && rs1 == bus.o_rd) || (use_rs2 && rs2 == bus.o_rd));
   assign bus.o_ready = advance && !hazard;

   // Bubbles and flushes clear only the control bits; data fields keep their last value.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bus.o_valid    <= 1'b0;
         bus.o_pc       <= '0;
         bus.o_rs1_data <= '0;
         bus.o_rs2_data <= '0;
         bus.o_imm      <= '0;
         bus.o_rs1      <= '0;
         bus.o_rs2      <= '0;
         bus.o_rd       <= '0;
         bus.o_opcode   <= '0;
         bus.o_funct3   <= '0;
         bus.o_funct7b5 <= 1'b0;
         bus.o_reg_wren <= 1'b0;
         bus.o_mem_rd   <= 1'b0;
         bus.o_mem_wren <= 1'b0;
         bus.o_illegal  <= 1'b0;
      end else if (bus.i_flush || (advance && !(bus.i_valid && !hazard))) begin
         bus.o_valid    <= 1'b0;
         bus.o_reg_wren <= 1'b0;
         bus.o_mem_rd   <= 1'b0;
         bus.o_mem_wren <= 1'b0;
         bus.o_illegal  <= 1'b0;
      end else if (advance) begin
         bus.o_valid    <= 1'b1;
         bus.o_pc       <= bus.i_pc;
         bus.o_rs1_data <= rs1_val;
         bus.o_rs2_data <= rs2_val;
         bus.o_imm      <= imm;
         bus.o_rs1      <= rs1;
         bus.o_rs2      <= rs2;
         bus.o_rd       <= rd;
         bus.o_opcode   <= opc;
         bus.o_funct3   <= inst[14:12];
         bus.o_funct7b5 <= inst[30];
         bus.o_reg_wren <= !illegal && writes_rd && (rd != 5'd0);
         bus.o_mem_rd   <= !illegal && (opc == OP_LOAD);
         bus.o_mem_wren <= !illegal && (opc == OP_STORE);
         bus.o_illegal  <= illegal;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bus.o_stall_cnt <= '0;
      end else if (advance && hazard && !bus.i_flush && bus.o_stall_cnt != '1) begin
         bus.o_stall_cnt <= bus.o_stall_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a BYPASS=1 instance and a BYPASS=0 instance with a
// 2-bit stall counter share the same stimulus.
module tb_id_stage_pipe;
   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;

   always #5 i_clk = ~i_clk;

   id_stage_pipe_if #(.XLEN(32), .CNT_W(16)) b1 ();
   id_stage_pipe_if #(.XLEN(32), .CNT_W(2))  b0 ();

   id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1), .CNT_W(16)) u_dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(b1.slave));
   id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(0), .CNT_W(2)) u_dut0 (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(b0.slave));

   assign b0.i_valid    = b1.i_valid;
   assign b0.i_inst     = b1.i_inst;
   assign b0.i_pc       = b1.i_pc;
   assign b0.i_flush    = b1.i_flush;
   assign b0.i_ex_ready = b1.i_ex_ready;
   assign b0.i_wb_wren  = b1.i_wb_wren;
   assign b0.i_wb_rd    = b1.i_wb_rd;
   assign b0.i_wb_data  = b1.i_wb_data;

   localparam logic [31:0] ADD_X6_X5 = 32'h0002_8333;
   localparam logic [31:0] ADD_X8_X0 = 32'h0020_0433;
   localparam logic [31:0] LW_X7     = 32'h0000_A383;
   localparam logic [31:0] LW_X0     = 32'h0000_A003;
   localparam logic [31:0] ADD_DEP   = 32'h0023_8433;
   localparam logic [31:0] LUI_X7    = 32'h1234_53B7;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        reg_wren;
      logic        mem_rd;
      logic        mem_wren;
      logic        illegal;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic present(input logic [31:0] inst, input logic [31:0] pc);
      b1.i_valid = 1'b1;
      b1.i_inst  = inst;
      b1.i_pc    = pc;
      #1;
   endtask

   task automatic chk_cnt(input string name);
      chk({name, "_cnt1"}, 64'(b1.o_stall_cnt), 64'(exp_cnt));
      chk({name, "_cnt0"}, 64'(b0.o_stall_cnt), 64'((exp_cnt > 3) ? 3 : exp_cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'hFFF0_0093, 32'hFFFF_FFFF, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // addi x1,x0,-1
      vecs[1] = '{32'h0020_A223, 32'h0000_0004, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0}; // sw x2,4(x1)
      vecs[2] = '{32'hFE00_0CE3, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0}; // beq -8
      vecs[3] = '{LUI_X7,        32'h1234_5000, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0}; // lui
      vecs[4] = '{32'hFFDF_F0EF, 32'hFFFF_FFFC, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,-4
      vecs[5] = '{32'h0000_00FF, 32'h0000_0000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1}; // opcode 7F
      vecs[6] = '{32'h0081_A483, 32'h0000_0008, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0}; // lw x9,8(x3)
      vecs[7] = '{32'h0020_8033, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // add x0
      vecs[8] = '{32'h8000_0197, 32'h8000_0000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0}; // auipc

      b1.i_valid = 1'b0; b1.i_inst = '0; b1.i_pc = '0; b1.i_flush = 1'b0;
      b1.i_ex_ready = 1'b1; b1.i_wb_wren = 1'b0; b1.i_wb_rd = '0; b1.i_wb_data = '0;
      step(); step();
      i_reset_n = 1'b1;
      #1;
      chk("rst_valid", 64'(b1.o_valid), 64'd0);
      chk("rst_rs1", b1.o_rs1_data, 64'd0);
      chk("rst_ready", 64'(b1.o_ready), 64'd1);
      chk_cnt("rst");

      // WB write to x5 in the same cycle ID reads it
      b1.i_wb_wren = 1'b1; b1.i_wb_rd = 5'd5; b1.i_wb_data = 32'hDEAD_BEEF;
      present(ADD_X6_X5, 32'h100);
      step();
      chk("byp1_rs1", b1.o_rs1_data, 64'hDEAD_BEEF);
      chk("byp0_rs1", b0.o_rs1_data, 64'd0);
      chk("byp_valid", 64'(b1.o_valid), 64'd1);
      chk("byp_rd", 64'(b1.o_rd), 64'd6);
      b1.i_wb_wren = 1'b0;
      present(ADD_X6_X5, 32'h104);
      step();
      chk("nobyp0_rs1", b0.o_rs1_data, 64'hDEAD_BEEF);
      chk("nobyp1_rs1", b1.o_rs1_data, 64'hDEAD_BEEF);
      b1.i_wb_wren = 1'b1; b1.i_wb_rd = 5'd0; b1.i_wb_data = 32'h1234;
      present(ADD_X8_X0, 32'h108);
      step();
      chk("x0_byp", b1.o_rs1_data, 64'd0);
      b1.i_wb_wren = 1'b0;

      // load-use: exactly one bubble
      present(LW_X7, 32'h10C);
      chk("lu_ready_lw", 64'(b1.o_ready), 64'd1);
      step();
      chk("lu_mem_rd", 64'(b1.o_mem_rd), 64'd1);
      present(ADD_DEP, 32'h110);
      chk("lu_ready_haz", 64'(b1.o_ready), 64'd0);
      step();
      exp_cnt++;
      chk("lu_bubble_valid", 64'(b1.o_valid), 64'd0);
      chk("lu_bubble_mem_rd", 64'(b1.o_mem_rd), 64'd0);
      chk_cnt("lu");
      chk("lu_ready_after", 64'(b1.o_ready), 64'd1);
      step();
      chk("lu_issue_valid", 64'(b1.o_valid), 64'd1);
      chk("lu_issue_rd", 64'(b1.o_rd), 64'd8);
      chk("lu_issue_pc", b1.o_pc, 64'h110);

      // no hazard through x0 or for an instruction that does not read rs1
      present(LW_X0, 32'h114);
      step();
      present(ADD_X8_X0, 32'h118);
      chk("x0_ready", 64'(b1.o_ready), 64'd1);
      step();
      present(LW_X7, 32'h11C);
      step();
      present(LUI_X7, 32'h120);
      chk("lui_ready", 64'(b1.o_ready), 64'd1);
      step();
      chk("lui_valid", 64'(b1.o_valid), 64'd1);
      chk_cnt("nohaz");

      // repeated load-use pairs drive the 2-bit counter into saturation
      for (int n = 0; n < 3; n++) begin
         present(LW_X7, 32'h200);
         step();
         present(ADD_DEP, 32'h204);
         step();
         step();
         exp_cnt++;
         chk_cnt("sat");
      end

      // EX back-pressure with a pending hazard, then flush
      present(LW_X7, 32'h300);
      step();
      b1.i_ex_ready = 1'b0;
      present(ADD_DEP, 32'h304);
      for (int n = 0; n < 3; n++) begin
         chk("bp_ready", 64'(b1.o_ready), 64'd0);
         step();
         chk("bp_valid", 64'(b1.o_valid), 64'd1);
         chk("bp_pc", b1.o_pc, 64'h300);
         chk("bp_mem_rd", 64'(b1.o_mem_rd), 64'd1);
      end
      chk_cnt("bp");
      b1.i_flush = 1'b1;
      step();
      chk("bp_flush_valid", 64'(b1.o_valid), 64'd0);
      chk("bp_flush_mem_rd", 64'(b1.o_mem_rd), 64'd0);
      b1.i_flush = 1'b0; b1.i_ex_ready = 1'b1;
      #1;
      chk("bp_ready_after", 64'(b1.o_ready), 64'd1);

      // flush coinciding with an advancing hazard is not counted
      present(LW_X7, 32'h400);
      step();
      present(ADD_DEP, 32'h404);
      b1.i_flush = 1'b1;
      step();
      b1.i_flush = 1'b0;
      chk("fh_valid", 64'(b1.o_valid), 64'd0);
      chk_cnt("fh");

      // decode table
      b1.i_valid = 1'b0;
      step();
      for (int i = 0; i < 9; i++) begin
         present(vecs[i].inst, 32'h1000 + 32'(4 * i));
         step();
         chk($sformatf("tbl%0d_valid", i), 64'(b1.o_valid), 64'd1);
         chk($sformatf("tbl%0d_pc", i), b1.o_pc, 64'(32'h1000 + 32'(4 * i)));
         chk($sformatf("tbl%0d_imm", i), b1.o_imm, 64'(vecs[i].imm));
         chk($sformatf("tbl%0d_rd", i), 64'(b1.o_rd), 64'(vecs[i].rd));
         chk($sformatf("tbl%0d_opc", i), 64'(b1.o_opcode), 64'(vecs[i].inst[6:0]));
         chk($sformatf("tbl%0d_wren", i), 64'(b1.o_reg_wren), 64'(vecs[i].reg_wren));
         chk($sformatf("tbl%0d_mrd", i), 64'(b1.o_mem_rd), 64'(vecs[i].mem_rd));
         chk($sformatf("tbl%0d_mwr", i), 64'(b1.o_mem_wren), 64'(vecs[i].mem_wren));
         chk($sformatf("tbl%0d_ill", i), 64'(b1.o_illegal), 64'(vecs[i].illegal));
      end

      // reset mid-stream
      present(ADD_X6_X5, 32'h500);
      step();
      chk("mr_pre_valid", 64'(b1.o_valid), 64'd1);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("mr_valid", 64'(b1.o_valid), 64'd0);
      exp_cnt = 0;
      chk_cnt("mr");
      step();
      i_reset_n = 1'b1;
      present(ADD_X6_X5, 32'h504);
      step();
      chk("mr_x5", b1.o_rs1_data, 64'd0);
      chk("mr_x5_0", b0.o_rs1_data, 64'd0);
      chk("mr_issue", 64'(b1.o_valid), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
